fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters sharing one FIFO write port.
REQ-002 Parameter WIDTH, default 8, data width in bits, matching the FIFO data width.
REQ-003 Parameter MAX_BURST, default 4, maximum consecutive beats per grant (>=1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req  input  N  per-requester beat-valid; requester n holds its beat on din slice n while req[n]=1.
REQ-007 din  input  N*WIDTH  flattened request data; slice n = din[n*WIDTH +: WIDTH].
REQ-008 ack  output  N  per-requester accept strobe, one-hot or zero; beat consumed in the cycle ack[n]=1.
REQ-009 fifo_full  input  1  FIFO full flag.
REQ-010 fifo_wrt  output  1  FIFO write enable.
REQ-011 fifo_din  output  WIDTH  FIFO write data.
REQ-012 grant_id  output  $clog2(N)  current owner index; valid only while busy=1, 0 otherwise.
REQ-013 busy  output  1  1 while in state GRANT.

Function
REQ-014 States: IDLE (no owner) and GRANT (owner registered); state, owner, rr_ptr and beat_cnt are registers.
REQ-015 Selection: first n with req[n]=1, searching rr_ptr, rr_ptr+1, ... mod N.
REQ-016 IDLE: if any req, next state GRANT, owner=selected, beat_cnt=0; no write and no ack in IDLE.
REQ-017 Grant latency is exactly one cycle from req rising in IDLE to the first possible accept.
REQ-018 GRANT: accept = req[owner] & ~fifo_full; accept drives fifo_wrt=1, ack[owner]=1 and fifo_din=din slice owner, all combinational in the same cycle.
REQ-019 fifo_din = 0 whenever fifo_wrt=0.
REQ-020 Each accept increments beat_cnt; fifo_full=1 stalls the owner: no accept, beat_cnt held, grant held.
REQ-021 Release when req[owner]=0, or when an accept occurs with beat_cnt=MAX_BURST-1.
REQ-022 On release: rr_ptr=(owner+1) mod N; re-run selection from the new rr_ptr with the current req.
REQ-023 If the re-run selection finds a requester, next state is GRANT with the new owner and beat_cnt=0, with no idle gap; otherwise next state is IDLE.
REQ-024 An owner released by burst limit that still requests is eligible only after all other requesters (lowest priority).
REQ-025 Never more than one ack bit set; fifo_wrt=1 implies fifo_full=0 in the same cycle.
REQ-026 Requester n dropping req without ack is legal; no beat is written for it.

Reset
REQ-027 While rst=1, fifo_wrt=0 and ack=0 combinationally, even mid-burst.
REQ-028 On a rising edge with rst=1: state=IDLE, owner=0, rr_ptr=0, beat_cnt=0; busy=0, grant_id=0, fifo_din=0.
REQ-029 The first selection after reset deassertion starts from requester 0.

Structure
REQ-030 Shared package fifo_arb_pkg holds the state enum (IDLE, GRANT) and the default N, WIDTH and MAX_BURST constants.
REQ-031 One combinational sub-module rr_pick(N) takes req and a start pointer and returns found and an index; it is instantiated once.
REQ-032 The REQ-016 and REQ-022 selections share that single instance, with the pointer muxed between rr_ptr and (owner+1) mod N.

Verification (N=4, WIDTH=8, MAX_BURST=4, FIFO depth 16)
REQ-033 Single requester: req[2]=1 with data 8'hA5 for 3 beats, then drop -> one cycle later 3 writes of A5 with ack[2], then IDLE and rr_ptr=3.
REQ-034 All four requesters continuously requesting, data 8'h10+n -> grant order 0,1,2,3,0; bursts of exactly 4 beats; back-to-back with no idle cycle.
REQ-035 fifo_full=1 for 3 cycles mid-burst of requester 1 -> fifo_wrt=0 and ack=0 for those cycles; grant held; the burst completes with 4 total writes.
REQ-036 req[0] and req[3] only, owner 3 hits the burst limit -> next owner is 0, not 3.
REQ-037 rst=1 asserted at the 2nd beat of a burst -> fifo_wrt=0 in that cycle; next cycle busy=0, grant_id=0; the next grant goes to the lowest requesting index.
REQ-038 Scoreboard: FIFO readout order equals the accepted-beat order over 200 random req/full cycles; no data lost or duplicated.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
// Holds the arbiter state encoding and the default sizing constants
// used by fifo_wr_arbiter and rr_pick.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_N         = 4;
    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_MAX_BURST = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: purely combinational.
// Returns the first set bit of req_i, scanning start_i, start_i+1, ...
// modulo N.
// Ports:
//   req_i    [N-1:0]          request vector
//   start_i  [$clog2(N)-1:0]  index where the scan begins
//   found_o                   1 if any request bit is set
//   idx_o    [$clog2(N)-1:0]  selected index (0 when found_o=0)
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N = DEF_N
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] start_i,
    output logic                 found_o,
    output logic [$clog2(N)-1:0] idx_o
);

    localparam int unsigned IW = $clog2(N);

    logic [IW-1:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IW'((32'(start_i) + i) % N);
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Arbiter sharing one FIFO write port among N requesters.
// Round-robin grant with bursts of up to MAX_BURST beats per grant.
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   req        [N-1:0]        per-requester beat valid
//   din        [N*WIDTH-1:0]  flattened beat data, slice n = din[n*WIDTH +: WIDTH]
//   ack        [N-1:0]        per-requester accept strobe (one-hot or zero)
//   fifo_full                 FIFO full flag
//   fifo_wrt                  FIFO write enable
//   fifo_din   [WIDTH-1:0]    FIFO write data (0 when not writing)
//   grant_id   [$clog2(N)-1:0] current owner (0 when not busy)
//   busy                      1 while a requester owns the port
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N         = DEF_N,
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   din,
    output logic [N-1:0]         ack,
    input  logic                 fifo_full,
    output logic                 fifo_wrt,
    output logic [WIDTH-1:0]     fifo_din,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    arb_state_e    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;

    logic [IW-1:0] owner_nxt;
    logic [IW-1:0] pick_start;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          accept;
    logic          last_beat;
    logic          release_grant;

    assign owner_nxt = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;

    // Single picker: in IDLE it scans from rr_ptr, in GRANT it pre-computes
    // the successor scan from owner+1 (the rr_ptr value a release would load).
    assign pick_start = (state_q == GRANT) ? owner_nxt : rr_ptr_q;

    rr_pick #(
        .N(N)
    ) u_pick (
        .req_i   (req),
        .start_i (pick_start),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign accept        = (state_q == GRANT) && req[owner_q] && !fifo_full && !rst;
    assign last_beat     = (beat_cnt_q == BW'(MAX_BURST - 1));
    assign release_grant = (state_q == GRANT) && (!req[owner_q] || (accept && last_beat));

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = GRANT;
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                if (release_grant) begin
                    rr_ptr_d   = owner_nxt;
                    beat_cnt_d = '0;
                    if (pick_found) begin
                        owner_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_wrt = accept;
        ack      = accept ? (N'(1) << owner_q) : '0;
        fifo_din = '0;
        for (int unsigned n = 0; n < N; n++) begin
            if (accept && (owner_q == IW'(n))) begin
                fifo_din = din[n*WIDTH +: WIDTH];
            end
        end
    end

    assign busy     = (state_q == GRANT);
    assign grant_id = (state_q == GRANT) ? owner_q : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule
